// File: rtl/uart_autobaud_rx.sv
// uart_autobaud_rx
//
// 8N1 UART receiver for the debug command channel. It learns its bit time
// from the first character on the line. That character must be 'a' (8'h61)
// or 'i' (8'h69). Both have bit 0 set, so the first low run on the line is
// exactly one start bit.
//
// Ports
//   clk      in   system clock; all state changes on its rising edge
//   nreset   in   asynchronous active-low reset
//   rxd      in   asynchronous serial line, idle high, LSB first
//   relearn  in   synchronous pulse; drops lock and restarts bit-time hunting
//   id       out  last received byte; held between dix strobes
//   dix      out  one-cycle strobe; id is valid in the same cycle
//   locked   out  high while the bit time is known
//   ferr     out  one-cycle strobe on a framing error (low stop bit)
//
// Timing
//   All sample points come from one down-counter (cnt_q). A sample is taken
//   in the cycle where cnt_q == 1, and the counter then reloads with B.
//   The counter therefore never exceeds B.
//   Loading floor(B/2) at t0 (or at tf) puts the first sample at
//   t0 + floor(B/2) (or tf + floor(B/2)).

module uart_autobaud_rx #(
    parameter int CNTW   = 16,
    parameter int MINBIT = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       rxd,
    input  logic       relearn,
    output logic [7:0] id,
    output logic       dix,
    output logic       locked,
    output logic       ferr
);

    localparam logic [2:0] HUNT    = 3'd0;
    localparam logic [2:0] MEASURE = 3'd1;
    localparam logic [2:0] FIRST   = 3'd2;
    localparam logic [2:0] IDLE    = 3'd3;
    localparam logic [2:0] START   = 3'd4;
    localparam logic [2:0] DATA    = 3'd5;
    localparam logic [2:0] STOP    = 3'd6;
    localparam logic [2:0] WAITHI  = 3'd7;

    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MIN = CNTW'(MINBIT);

    logic            sync1_q;
    logic            line_q;
    logic [2:0]      state_q,  state_d;
    logic [CNTW-1:0] cnt_q,    cnt_d;
    logic [CNTW-1:0] b_q,      b_d;
    logic [3:0]      bitn_q,   bitn_d;
    logic [3:0]      brk_q,    brk_d;
    logic [7:0]      sh_q,     sh_d;
    logic [7:0]      id_q,     id_d;
    logic            dix_q,    dix_d;
    logic            ferr_q,   ferr_d;
    logic            locked_q, locked_d;

    logic            sample;
    logic [CNTW-1:0] half_meas;
    logic [CNTW-1:0] half_b;

    assign sample = (cnt_q == CNT_ONE);

    // A half-bit of zero would make the down-counter wrap. That can only
    // happen when MINBIT < 2, so clamp the half-bit to 1 in that case.
    assign half_meas = ((cnt_q >> 1) == '0) ? CNT_ONE : (cnt_q >> 1);
    assign half_b    = ((b_q   >> 1) == '0) ? CNT_ONE : (b_q   >> 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        bitn_d   = bitn_q;
        brk_d    = brk_q;
        sh_d     = sh_q;
        id_d     = id_q;
        dix_d    = 1'b0;
        ferr_d   = 1'b0;
        locked_d = locked_q;

        if (relearn) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            b_d      = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    locked_d = 1'b0;
                    if (!line_q) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                    end
                end

                MEASURE: begin
                    if (line_q) begin
                        // The first high cycle is t0; the low run length is B.
                        if (cnt_q >= CNT_MIN) begin
                            b_d     = cnt_q;
                            cnt_d   = half_meas;
                            bitn_d  = 4'd0;
                            state_d = FIRST;
                        end else begin
                            b_d     = '0;
                            state_d = HUNT;
                        end
                    end else if (cnt_q == '1) begin
                        // Line stuck low longer than the counter can measure.
                        locked_d = 1'b0;
                        state_d  = WAITHI;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                FIRST: begin
                    if (sample) begin
                        cnt_d = b_q;
                        if (bitn_q == 4'd8) begin
                            if (line_q && (sh_q == 8'h61 || sh_q == 8'h69)) begin
                                locked_d = 1'b1;
                                id_d     = sh_q;
                                dix_d    = 1'b1;
                                state_d  = IDLE;
                            end else begin
                                b_d     = '0;
                                state_d = line_q ? HUNT : WAITHI;
                            end
                        end else begin
                            sh_d   = {line_q, sh_q[7:1]};
                            bitn_d = bitn_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                IDLE: begin
                    if (!line_q) begin
                        cnt_d   = half_b;
                        state_d = START;
                    end
                end

                START: begin
                    if (sample) begin
                        if (line_q) begin
                            // A start bit that is gone by mid-bit is a glitch.
                            state_d = IDLE;
                        end else begin
                            cnt_d   = b_q;
                            bitn_d  = 4'd0;
                            state_d = DATA;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                DATA: begin
                    if (sample) begin
                        cnt_d = b_q;
                        sh_d  = {line_q, sh_q[7:1]};
                        if (bitn_q == 4'd7) begin
                            state_d = STOP;
                        end else begin
                            bitn_d = bitn_q + 4'd1;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                STOP: begin
                    if (sample) begin
                        if (line_q) begin
                            id_d    = sh_q;
                            dix_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            // Arm break detection: count 16 periods of B.
                            ferr_d  = 1'b1;
                            cnt_d   = b_q;
                            brk_d   = 4'd0;
                            state_d = WAITHI;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end

                default: begin // WAITHI
                    if (line_q) begin
                        state_d = locked_q ? IDLE : HUNT;
                    end else if (locked_q) begin
                        if (sample) begin
                            cnt_d = b_q;
                            if (brk_q == 4'd15) begin
                                locked_d = 1'b0;
                            end else begin
                                brk_d = brk_q + 4'd1;
                            end
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_q  <= 1'b1;
            line_q   <= 1'b1;
            state_q  <= HUNT;
            cnt_q    <= '0;
            b_q      <= '0;
            bitn_q   <= 4'd0;
            brk_q    <= 4'd0;
            sh_q     <= 8'h00;
            id_q     <= 8'h00;
            dix_q    <= 1'b0;
            ferr_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            sync1_q  <= rxd;
            line_q   <= sync1_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            bitn_q   <= bitn_d;
            brk_q    <= brk_d;
            sh_q     <= sh_d;
            id_q     <= id_d;
            dix_q    <= dix_d;
            ferr_q   <= ferr_d;
            locked_q <= locked_d;
        end
    end

    assign id     = id_q;
    assign dix    = dix_q;
    assign locked = locked_q;
    assign ferr   = ferr_q;

endmodule

// File: tb/tb_uart_autobaud_rx.sv
// Directed testbench for uart_autobaud_rx.
//
// Frames are driven one bit time per B clock cycles. Each drive happens 1 ns
// after a rising edge.
//
// A strobe for a frame whose start bit is driven at cycle n0 is expected at
// cycle n0 + 3 + floor(B/2) + 9*B. The 3 cycles are two synchronizer stages
// plus the registered output.

module tb_uart_autobaud_rx;

    logic       clk = 1'b0;
    logic       nreset;
    logic       rxd;
    logic       relearn;
    logic [7:0] id;
    logic       dix;
    logic       locked;
    logic       ferr;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    int         dix_cnt  = 0;
    int         dix_cyc  = 0;
    logic [7:0] dix_id   = 8'h00;
    int         ferr_cnt = 0;
    int         ferr_cyc = 0;

    uart_autobaud_rx #(.CNTW(16), .MINBIT(4)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .rxd     (rxd),
        .relearn (relearn),
        .id      (id),
        .dix     (dix),
        .locked  (locked),
        .ferr    (ferr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (dix) begin
            dix_cnt = dix_cnt + 1;
            dix_cyc = cyc;
            dix_id  = id;
        end
        if (ferr) begin
            ferr_cnt = ferr_cnt + 1;
            ferr_cyc = cyc;
        end
        if (dix && ferr) begin
            n_fail = n_fail + 1;
            $display("FAIL dix_ferr_overlap: dix=%b ferr=%b at cycle %0d, required never both high", dix, ferr, cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            rxd = 1'b1;
        end
    endtask

    task automatic hold_low(input int n);
        repeat (n) begin
            tick();
            rxd = 1'b0;
        end
    endtask

    // Drives start + 8 data + stop, each bt cycles long.
    // rxd is left at the stop level when the task returns.
    task automatic send_frame(input logic [7:0] b, input int bt, input logic stop, output int n0);
        tick();
        rxd = 1'b0;
        n0  = cyc;
        repeat (bt - 1) tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            rxd = b[k];
            repeat (bt - 1) tick();
        end
        tick();
        rxd = stop;
        repeat (bt - 1) tick();
        $display("frame byte=%h B=%0d stop=%b start_cycle=%0d", b, bt, stop, n0);
    endtask

    task automatic test_reset();
        nreset  = 1'b0;
        rxd     = 1'b1;
        relearn = 1'b0;
        repeat (4) tick();
        n_cmp++; if (id !== 8'h00)   begin n_fail++; $display("FAIL reset_id: got %h expected 00", id); end
        n_cmp++; if (dix !== 1'b0)   begin n_fail++; $display("FAIL reset_dix: got %b expected 0", dix); end
        n_cmp++; if (ferr !== 1'b0)  begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", ferr); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        nreset = 1'b1;
        idle(10);
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL post_reset_locked: got %b expected 0", locked); end
        $display("reset done");
    endtask

    task automatic test_first_lock();
        int n0;
        int d0;
        d0 = dix_cnt;
        send_frame(8'h61, 16, 1'b1, n0);
        idle(5);
        n_cmp++; if (dix_cnt !== d0 + 1) begin n_fail++; $display("FAIL lock_a_count: got %0d strobes expected 1", dix_cnt - d0); end
        n_cmp++; if (dix_id !== 8'h61) begin n_fail++; $display("FAIL lock_a_id: got %h expected 61", dix_id); end
        n_cmp++; if (dix_cyc !== n0 + 155) begin n_fail++; $display("FAIL lock_a_timing: got cycle %0d expected %0d", dix_cyc, n0 + 155); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_a_locked: got %b expected 1", locked); end
        n_cmp++; if (id !== 8'h61) begin n_fail++; $display("FAIL lock_a_hold_id: got %h expected 61", id); end
    endtask

    task automatic test_back_to_back();
        int n0;
        int d0;
        int c1;
        logic [7:0] id1;
        d0 = dix_cnt;
        send_frame(8'h72, 16, 1'b1, n0);
        c1  = dix_cyc;
        id1 = dix_id;
        send_frame(8'h77, 16, 1'b1, n0);
        idle(5);
        n_cmp++; if (dix_cnt !== d0 + 2) begin n_fail++; $display("FAIL b2b_count: got %0d strobes expected 2", dix_cnt - d0); end
        n_cmp++; if (id1 !== 8'h72) begin n_fail++; $display("FAIL b2b_id1: got %h expected 72", id1); end
        n_cmp++; if (dix_id !== 8'h77) begin n_fail++; $display("FAIL b2b_id2: got %h expected 77", dix_id); end
        n_cmp++; if (dix_cyc - c1 !== 160) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected 160", dix_cyc - c1); end
    endtask

    task automatic test_glitch();
        int n0;
        int d0;
        int f0;
        d0 = dix_cnt;
        f0 = ferr_cnt;
        hold_low(3);
        idle(30);
        $display("glitch 3 cycles low");
        n_cmp++; if (dix_cnt !== d0) begin n_fail++; $display("FAIL glitch_dix: got %0d strobes expected 0", dix_cnt - d0); end
        n_cmp++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d strobes expected 0", ferr_cnt - f0); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL glitch_locked: got %b expected 1", locked); end
        send_frame(8'h5A, 16, 1'b1, n0);
        idle(5);
        n_cmp++; if (dix_cnt !== d0 + 1) begin n_fail++; $display("FAIL glitch_next_count: got %0d strobes expected 1", dix_cnt - d0); end
        n_cmp++; if (dix_id !== 8'h5A) begin n_fail++; $display("FAIL glitch_next_id: got %h expected 5a", dix_id); end
        n_cmp++; if (dix_cyc !== n0 + 155) begin n_fail++; $display("FAIL glitch_next_timing: got cycle %0d expected %0d", dix_cyc, n0 + 155); end
    endtask

    task automatic test_framing_break();
        int n0;
        int d0;
        int f0;
        d0 = dix_cnt;
        f0 = ferr_cnt;
        send_frame(8'h33, 16, 1'b0, n0);
        hold_low(100);
        n_cmp++; if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_count: got %0d strobes expected 1", ferr_cnt - f0); end
        n_cmp++; if (ferr_cyc !== n0 + 155) begin n_fail++; $display("FAIL ferr_timing: got cycle %0d expected %0d", ferr_cyc, n0 + 155); end
        n_cmp++; if (dix_cnt !== d0) begin n_fail++; $display("FAIL ferr_no_dix: got %0d strobes expected 0", dix_cnt - d0); end
        n_cmp++; if (id !== 8'h5A) begin n_fail++; $display("FAIL ferr_id_held: got %h expected 5a", id); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL ferr_still_locked: got %b expected 1", locked); end
        hold_low(160);
        $display("break held low");
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL break_unlock: got %b expected 0", locked); end
        idle(20);
    endtask

    task automatic test_reject_then_lock();
        int n0;
        int d0;
        d0 = dix_cnt;
        send_frame(8'h78, 16, 1'b1, n0);
        idle(700);
        n_cmp++; if (dix_cnt !== d0) begin n_fail++; $display("FAIL reject_x_dix: got %0d strobes expected 0", dix_cnt - d0); end
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reject_x_locked: got %b expected 0", locked); end
        send_frame(8'h69, 16, 1'b1, n0);
        idle(5);
        n_cmp++; if (dix_cnt !== d0 + 1) begin n_fail++; $display("FAIL lock_i_count: got %0d strobes expected 1", dix_cnt - d0); end
        n_cmp++; if (id !== 8'h69) begin n_fail++; $display("FAIL lock_i_id: got %h expected 69", id); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_i_locked: got %b expected 1", locked); end
    endtask

    task automatic test_relearn();
        int n0;
        int d0;
        int f0;
        logic [7:0] r;
        r  = 8'h72;
        d0 = dix_cnt;
        f0 = ferr_cnt;
        // Start bit plus three data bits of 'r', then abort.
        hold_low(16);
        for (int k = 0; k < 3; k++) begin
            tick();
            rxd = r[k];
            repeat (15) tick();
        end
        tick();
        rxd     = 1'b1;
        relearn = 1'b1;
        tick();
        relearn = 1'b0;
        $display("relearn pulse at cycle %0d", cyc);
        n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL relearn_unlock: got %b expected 0", locked); end
        idle(60);
        n_cmp++; if (dix_cnt !== d0) begin n_fail++; $display("FAIL relearn_no_dix: got %0d strobes expected 0", dix_cnt - d0); end
        n_cmp++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL relearn_no_ferr: got %0d strobes expected 0", ferr_cnt - f0); end
        send_frame(8'h61, 40, 1'b1, n0);
        idle(5);
        n_cmp++; if (dix_cnt !== d0 + 1) begin n_fail++; $display("FAIL relock40_count: got %0d strobes expected 1", dix_cnt - d0); end
        n_cmp++; if (dix_id !== 8'h61) begin n_fail++; $display("FAIL relock40_id: got %h expected 61", dix_id); end
        n_cmp++; if (dix_cyc !== n0 + 383) begin n_fail++; $display("FAIL relock40_timing: got cycle %0d expected %0d", dix_cyc, n0 + 383); end
        n_cmp++; if (locked !== 1'b1) begin n_fail++; $display("FAIL relock40_locked: got %b expected 1", locked); end
    endtask

    initial begin
        test_reset();
        test_first_lock();
        test_back_to_back();
        test_glitch();
        test_framing_break();
        test_reject_then_lock();
        test_relearn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
